// File: rtl/fir_feeder.sv
// fir_feeder: tagged host words -> sample FIFO streamed on fir_tvalid, full coefficient sets replayed last-to-first on fir_set_coeffs; ports clk, reset, in_data/in_is_coef/in_valid/in_ready, fir_x_n/fir_tvalid/fir_set_coeffs, busy, plus underrun_cnt when FIR_FEEDER_UNDERRUN_CNT_EN is defined
module fir_feeder #(
  parameter int TAP_SIZE    = 3,
  parameter int NBR_OF_TAPS = 6,
  parameter int X_N_SIZE    = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [X_N_SIZE-1:0] in_data,
  input  logic                in_is_coef,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [X_N_SIZE-1:0] fir_x_n,
  output logic                fir_tvalid,
  output logic                fir_set_coeffs,
  output logic                busy
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]          underrun_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (NBR_OF_TAPS > 1) ? $clog2(NBR_OF_TAPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBR_OF_TAPS - 1);
  typedef enum logic [1:0] {IDLE, STREAM, CFG_LOAD, CFG_GAP} state_t;
  state_t r_state, w_next;
  logic [TAP_SIZE-1:0] r_coef [NBR_OF_TAPS];
  logic [X_N_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp, w_wp_n, w_rp_n;
  logic [CW-1:0] r_cnt, r_idx, w_idx, w_sel;
  logic r_pend, w_pend_n, w_clr, w_pop, w_push, w_coef_wr, w_empty, w_full;
  logic w_tvalid, w_set, w_busy, w_underrun;
  logic [X_N_SIZE-1:0] w_x_n, w_coef_ext;
  logic [TAP_SIZE-1:0] w_coef;
  assign w_empty    = r_wp == r_rp;
  assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign in_ready   = in_is_coef ? !r_pend : !w_full;
  assign w_push     = in_valid && !in_is_coef && !w_full;
  assign w_coef_wr  = in_valid && in_is_coef && !r_pend;
  // r_idx is the index on the output now; entry into CFG_LOAD starts at the top tap
  assign w_sel      = (r_state == CFG_LOAD) ? r_idx - CW'(1) : LAST;
  assign w_coef     = r_coef[w_sel];
  assign w_coef_ext = X_N_SIZE'($signed(w_coef));
  assign w_wp_n     = r_wp + (AW+1)'(w_push);
  assign w_rp_n     = r_rp + (AW+1)'(w_pop);
  assign w_pend_n   = (r_pend && !w_clr) || (w_coef_wr && r_cnt == LAST);
  assign w_busy     = (w_next != IDLE) || (w_wp_n != w_rp_n) || w_pend_n;
  // IDLE, STREAM and CFG_GAP share the same exit rules; outputs are computed for the state being entered
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_clr      = 1'b0;
    w_idx      = r_idx;
    w_x_n      = '0;
    w_tvalid   = 1'b0;
    w_set      = 1'b0;
    w_underrun = 1'b0;
    if (r_state == CFG_LOAD) begin
      if (r_idx == '0) begin
        w_next = CFG_GAP;
        w_clr  = 1'b1;
      end else begin
        w_idx = w_sel;
        w_x_n = w_coef_ext;
        w_set = 1'b1;
      end
    end else if (r_pend) begin
      w_next = CFG_LOAD;
      w_idx  = LAST;
      w_x_n  = w_coef_ext;
      w_set  = 1'b1;
    end else if (!w_empty) begin
      w_next   = STREAM;
      w_pop    = 1'b1;
      w_x_n    = r_mem[r_rp[AW-1:0]];
      w_tvalid = 1'b1;
    end else begin
      w_next     = IDLE;
      w_underrun = r_state == STREAM;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_wp           <= '0;
      r_rp           <= '0;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_pend         <= 1'b0;
      fir_x_n        <= '0;
      fir_tvalid     <= 1'b0;
      fir_set_coeffs <= 1'b0;
      busy           <= 1'b0;
      for (int i = 0; i < NBR_OF_TAPS; i++) r_coef[i] <= '0;
    end else begin
      r_state        <= w_next;
      r_wp           <= w_wp_n;
      r_rp           <= w_rp_n;
      r_idx          <= w_idx;
      r_pend         <= w_pend_n;
      fir_x_n        <= w_x_n;
      fir_tvalid     <= w_tvalid;
      fir_set_coeffs <= w_set;
      busy           <= w_busy;
      if (w_push) r_mem[r_wp[AW-1:0]] <= in_data;
      if (w_coef_wr) begin
        r_coef[r_cnt] <= in_data[TAP_SIZE-1:0];
        r_cnt         <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      end
    end
  end
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) underrun_cnt <= '0;
    else if (w_underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
  end
`else
  logic w_unused;
  assign w_unused = w_underrun;
`endif
endmodule

// File: tb/tb_fir_feeder.sv
// tb_fir_feeder: directed plus randomized host traffic checked against a cycle-level queue model of fir_feeder
module tb_fir_feeder;
  localparam int TAP = 3;
  localparam int N   = 6;
  localparam int W   = 8;
  localparam int D   = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_is_coef = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, fir_tvalid, fir_set_coeffs, busy;
  logic [W-1:0] fir_x_n;
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif
  fir_feeder #(.TAP_SIZE(TAP), .NBR_OF_TAPS(N), .X_N_SIZE(W), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_is_coef(in_is_coef),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .fir_x_n(fir_x_n),
    .fir_tvalid(fir_tvalid),
    .fir_set_coeffs(fir_set_coeffs),
    .busy(busy)
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int errs = 0;
  logic [TAP-1:0] m_coef [N];
  logic [W-1:0] m_q[$];
  int m_cnt = 0;
  int m_cfg_left = 0;
  int m_under = 0;
  bit m_pend = 0;
  bit m_gap = 0;
  bit m_stream = 0;
  logic [W-1:0] e_x = '0;
  bit e_tv = 0;
  bit e_set = 0;
  bit e_busy = 0;
  logic [W-1:0] seen_cfg[$], seen_smp[$], sent_smp[$];
  function automatic logic [W-1:0] sext(input logic [TAP-1:0] c);
    return {{(W-TAP){c[TAP-1]}}, c};
  endfunction
  function automatic bit m_ready(input bit c);
    return c ? !m_pend : (m_q.size() < D);
  endfunction
  task automatic m_edge(input bit rst, input bit v, input bit c, input logic [W-1:0] d);
    bit acc;
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < N; i++) m_coef[i] = '0;
      m_cnt = 0; m_cfg_left = 0; m_under = 0;
      m_pend = 0; m_gap = 0; m_stream = 0;
      e_x = '0; e_tv = 0; e_set = 0; e_busy = 0;
      return;
    end
    acc = v && m_ready(c);
    e_x = '0; e_tv = 0; e_set = 0; m_gap = 0;
    if (m_cfg_left > 0) begin
      m_cfg_left--;
      if (m_cfg_left > 0) begin
        e_set = 1;
        e_x = sext(m_coef[m_cfg_left-1]);
      end else begin
        m_gap = 1;
        m_pend = 0;
      end
    end else if (m_pend) begin
      m_stream = 0;
      m_cfg_left = N;
      e_set = 1;
      e_x = sext(m_coef[N-1]);
    end else if (m_q.size() > 0) begin
      m_stream = 1;
      e_tv = 1;
      e_x = m_q.pop_front();
    end else begin
      if (m_stream && m_under < 255) m_under++;
      m_stream = 0;
    end
    if (acc) begin
      if (c) begin
        m_coef[m_cnt] = d[TAP-1:0];
        if (m_cnt == N-1) begin
          m_pend = 1;
          m_cnt = 0;
        end else m_cnt++;
      end else m_q.push_back(d);
    end
    e_busy = m_stream || m_cfg_left > 0 || m_gap || m_q.size() > 0 || m_pend;
  endtask
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit rst, input bit v, input bit c, input logic [W-1:0] d, output bit acc);
    reset = rst; in_valid = v; in_is_coef = c; in_data = d;
    #1;
    if (!rst) chk("in_ready", {7'b0, in_ready}, {7'b0, m_ready(c)});
    acc = !rst && v && m_ready(c);
    @(posedge clk);
    m_edge(rst, v, c, d);
    #1;
    chk("fir_x_n", fir_x_n, e_x);
    chk("fir_tvalid", {7'b0, fir_tvalid}, {7'b0, e_tv});
    chk("fir_set_coeffs", {7'b0, fir_set_coeffs}, {7'b0, e_set});
    chk("busy", {7'b0, busy}, {7'b0, e_busy});
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
    chk("underrun_cnt", underrun_cnt, W'(m_under));
`endif
    if (fir_set_coeffs) seen_cfg.push_back(fir_x_n);
    if (fir_tvalid) seen_smp.push_back(fir_x_n);
  endtask
  task automatic send(input bit c, input logic [W-1:0] d);
    bit a = 0;
    int n = 0;
    while (!a && n < 64) begin
      step(0, 1, c, d, a);
      n++;
    end
    chk("send_accepted", {7'b0, a}, 8'h01);
    if (a && !c) sent_smp.push_back(d);
  endtask
  task automatic idle(input int n);
    bit a;
    repeat (n) step(0, 0, 0, '0, a);
  endtask
  task automatic do_reset();
    bit a;
    step(1, 0, 0, '0, a);
    step(1, 0, 0, '0, a);
  endtask
  initial begin
    bit a, hv, hc;
    logic [W-1:0] hd, c6, c11;
    logic [W-1:0] exp_smp [3];
    logic [W-1:0] exp_cfg [6];
    logic [W-1:0] coefs [6];
    exp_smp = '{8'h05, 8'hFB, 8'h7F};
    exp_cfg = '{8'hFC, 8'hFF, 8'h03, 8'h02, 8'h01, 8'h00};
    coefs = '{8'hA0, 8'h51, 8'h32, 8'hE3, 8'h1F, 8'hC4};
    do_reset();
    idle(10);
    seen_smp.delete();
    send(0, 8'h05); send(0, 8'hFB); send(0, 8'h7F);
    idle(5);
    chk("smp_count", W'(seen_smp.size()), 8'd3);
    for (int i = 0; i < 3; i++) chk("smp_value", seen_smp[i], exp_smp[i]);
    seen_cfg.delete();
    for (int i = 0; i < 6; i++) send(1, coefs[i]);
    idle(10);
    chk("cfg_count", W'(seen_cfg.size()), 8'd6);
    for (int i = 0; i < 6; i++) chk("cfg_value", seen_cfg[i], exp_cfg[i]);
    seen_smp.delete(); sent_smp.delete();
    for (int i = 0; i < 6; i++) send(1, W'($urandom));
    for (int i = 0; i < 4; i++) send(0, W'($urandom));
    step(0, 1, 0, 8'h5A, a);
    chk("fifo_full_stall", {7'b0, a}, 8'h00);
    send(0, 8'h5A);
    idle(12);
    chk("fifo_count", W'(seen_smp.size()), W'(sent_smp.size()));
    for (int i = 0; i < 5; i++) chk("fifo_order", seen_smp[i], sent_smp[i]);
    for (int i = 0; i < 6; i++) send(1, W'($urandom));
    c6 = W'($urandom);
    send(1, c6);
    seen_cfg.delete();
    for (int i = 0; i < 5; i++) begin
      c11 = W'($urandom);
      send(1, c11);
    end
    idle(10);
    chk("next_set_count", W'(seen_cfg.size()), 8'd6);
    chk("held_coef_is_tap0", seen_cfg[5], sext(c6[TAP-1:0]));
    chk("last_coef_first", seen_cfg[0], sext(c11[TAP-1:0]));
    for (int i = 0; i < 6; i++) send(1, W'($urandom));
    idle(3);
    chk("third_load_cycle", {7'b0, fir_set_coeffs}, 8'h01);
    step(1, 0, 0, '0, a);
    chk("rst_abort_strobe", {6'b0, fir_set_coeffs, fir_tvalid}, 8'h00);
    seen_cfg.delete();
    idle(10);
    for (int i = 0; i < 5; i++) send(1, W'($urandom));
    idle(8);
    chk("no_resumed_load", W'(seen_cfg.size()), 8'd0);
    send(1, W'($urandom));
    idle(10);
    chk("fresh_set_count", W'(seen_cfg.size()), 8'd6);
    do_reset();
    send(0, 8'h11); send(0, 8'h22);
    idle(5);
`ifdef FIR_FEEDER_UNDERRUN_CNT_EN
    chk("underrun_one", underrun_cnt, 8'd1);
`endif
    hv = 0; hc = 0; hd = '0;
    for (int i = 0; i < 600; i++) begin
      bit rst;
      if (!hv && $urandom_range(0, 3) != 0) begin
        hv = 1;
        hc = ($urandom_range(0, 3) == 0);
        hd = W'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      step(rst, hv, hc, hd, a);
      if (a || rst) hv = 0;
    end
    idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
